// File: rtl/alu_mdu_seq.sv
// rtl/alu_mdu_seq.sv - sequential ALU with iterative multiply/divide behind valid/ready handshakes
// Ports: clk, rst_n (async, active-low)
//        request : in_valid, in_ready, alu_code[5:0], oprand_a, oprand_b
//        response: out_valid, out_ready, result
//        status  : busy (multiply/divide iterating)
module alu_mdu_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [5:0]            alu_code,
    input  logic [DATA_WIDTH-1:0] oprand_a,
    input  logic [DATA_WIDTH-1:0] oprand_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  busy
);
    localparam int W       = DATA_WIDTH;
    localparam int SHAMT_W = $clog2(W);
    localparam int CNT_W   = SHAMT_W + 1;

    localparam logic [5:0] OP_RAM    = 6'h00, OP_ADD  = 6'h01, OP_SLT  = 6'h02, OP_SLTU   = 6'h03;
    localparam logic [5:0] OP_SLL    = 6'h04, OP_SRL  = 6'h05, OP_SRA  = 6'h06, OP_XOR    = 6'h07;
    localparam logic [5:0] OP_OR     = 6'h08, OP_AND  = 6'h09, OP_SUB  = 6'h0A, OP_MUL    = 6'h0B;
    localparam logic [5:0] OP_MULH   = 6'h0C, OP_MULHSU = 6'h0D, OP_MULHU = 6'h0E, OP_DIV = 6'h0F;
    localparam logic [5:0] OP_DIVU   = 6'h10, OP_REM  = 6'h11, OP_REMU = 6'h12;

    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t             state, state_next;
    logic [5:0]         op_reg;
    logic [2*W-1:0]     acc;        // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [W-1:0]       opnd;       // multiplicand or divisor magnitude
    logic [CNT_W-1:0]   cnt;
    logic               neg;        // final result must be negated

    logic               accept, is_mul_op, is_div_op, a_signed, b_signed;
    logic               div_zero, div_ovf, shortcut, start_iter, last_iter, sa, sb;
    logic [W-1:0]       mag_a, mag_b, imm_result, fin_result;
    logic [SHAMT_W-1:0] shamt;
    logic               op_is_mul;
    logic [W:0]         mul_sum, div_diff;
    logic [2*W-1:0]     acc_next, prod_fix;

    // Request decode and single-cycle results
    always_comb begin
        accept     = in_valid && (state == S_IDLE);
        is_mul_op  = alu_code inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
        is_div_op  = alu_code inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        a_signed   = alu_code inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        b_signed   = alu_code inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
        sa         = a_signed && oprand_a[W-1];
        sb         = b_signed && oprand_b[W-1];
        mag_a      = sa ? -oprand_a : oprand_a;
        mag_b      = sb ? -oprand_b : oprand_b;
        div_zero   = is_div_op && (oprand_b == '0);
        div_ovf    = (alu_code == OP_DIV || alu_code == OP_REM) && (oprand_a == MIN_VAL) && (&oprand_b);
        shortcut   = div_zero || div_ovf;
        start_iter = accept && (is_mul_op || is_div_op) && !shortcut;
        shamt      = oprand_b[SHAMT_W-1:0];

        imm_result = '0;
        case (alu_code)
            OP_RAM, OP_ADD: imm_result = oprand_a + oprand_b;
            OP_SUB:         imm_result = oprand_a - oprand_b;
            OP_SLT:         imm_result = {{(W-1){1'b0}}, ($signed(oprand_a) < $signed(oprand_b))};
            OP_SLTU:        imm_result = {{(W-1){1'b0}}, (oprand_a < oprand_b)};
            OP_SLL:         imm_result = oprand_a << shamt;
            OP_SRL:         imm_result = oprand_a >> shamt;
            OP_SRA:         imm_result = $unsigned($signed(oprand_a) >>> shamt);
            OP_XOR:         imm_result = oprand_a ^ oprand_b;
            OP_OR:          imm_result = oprand_a | oprand_b;
            OP_AND:         imm_result = oprand_a & oprand_b;
            // Divide shortcuts only; the iterative paths never use these values
            OP_DIV:         imm_result = div_zero ? '1 : oprand_a;
            OP_DIVU:        imm_result = '1;
            OP_REM:         imm_result = div_zero ? oprand_a : '0;
            OP_REMU:        imm_result = oprand_a;
            default:        imm_result = '0;
        endcase
    end

    // One multiply or divide step, plus sign fix-up of the finished value
    always_comb begin
        op_is_mul = op_reg inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
        last_iter = (state == S_BUSY) && (cnt == CNT_W'(W - 1));
        mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
        div_diff  = acc[2*W-1:W-1] - {1'b0, opnd};
        if (op_is_mul)
            acc_next = {mul_sum, acc[W-1:1]};
        else if (div_diff[W])
            acc_next = {acc[2*W-2:0], 1'b0};
        else
            acc_next = {div_diff[W-1:0], acc[W-2:0], 1'b1};

        prod_fix = neg ? -acc_next : acc_next;
        fin_result = '0;
        case (op_reg)
            OP_MUL:                     fin_result = prod_fix[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fin_result = prod_fix[2*W-1:W];
            OP_DIV, OP_DIVU:            fin_result = neg ? -acc_next[W-1:0] : acc_next[W-1:0];
            OP_REM, OP_REMU:            fin_result = neg ? -acc_next[2*W-1:W] : acc_next[2*W-1:W];
            default:                    fin_result = '0;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = start_iter ? S_BUSY : S_DONE;
            S_BUSY:  if (last_iter) state_next = S_DONE;
            S_DONE:  if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready  = (state == S_IDLE);
        busy      = (state == S_BUSY);
        out_valid = (state == S_DONE);
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg <= '0;
            acc    <= '0;
            opnd   <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            result <= '0;
        end else if (accept) begin
            op_reg <= alu_code;
            cnt    <= '0;
            // remainder takes the dividend's sign; everything else sa^sb
            neg    <= (alu_code == OP_REM) ? sa : (sa ^ sb);
            if (start_iter) begin
                acc  <= {{W{1'b0}}, is_mul_op ? mag_b : mag_a};
                opnd <= is_mul_op ? mag_a : mag_b;
            end else begin
                result <= imm_result;
            end
        end else if (state == S_BUSY) begin
            acc <= acc_next;
            cnt <= cnt + CNT_W'(1);
            if (last_iter) result <= fin_result;
        end
    end
endmodule

// File: tb/tb_alu_mdu_seq.sv
// tb/tb_alu_mdu_seq.sv - self-checking bench for alu_mdu_seq at widths 32 and 16
module tb_alu_mdu_seq;
    logic        clk, rst_n;
    logic        in_valid32, in_ready32, out_valid32, out_ready32, busy32;
    logic [5:0]  code32;
    logic [31:0] a32, b32, result32;
    logic        in_valid16, in_ready16, out_valid16, out_ready16, busy16;
    logic [5:0]  code16;
    logic [15:0] a16, b16, result16;
    int          tests, fails;

    alu_mdu_seq #(.DATA_WIDTH(32)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .alu_code(code32), .oprand_a(a32), .oprand_b(b32), .out_valid(out_valid32),
        .out_ready(out_ready32), .result(result32), .busy(busy32));

    alu_mdu_seq #(.DATA_WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .alu_code(code16), .oprand_a(a16), .oprand_b(b16), .out_valid(out_valid16),
        .out_ready(out_ready16), .result(result16), .busy(busy16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int w, input logic v, input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
        if (w == 32) begin
            in_valid32 = v; code32 = c; a32 = a; b32 = b;
        end else begin
            in_valid16 = v; code16 = c; a16 = a[15:0]; b16 = b[15:0];
        end
    endtask

    task automatic set_ready(input int w, input logic r);
        if (w == 32) out_ready32 = r;
        else         out_ready16 = r;
    endtask

    function automatic logic get_ov(input int w);
        return (w == 32) ? out_valid32 : out_valid16;
    endfunction

    function automatic logic get_ir(input int w);
        return (w == 32) ? in_ready32 : in_ready16;
    endfunction

    function automatic logic [31:0] get_res(input int w);
        return (w == 32) ? result32 : {16'h0, result16};
    endfunction

    // Reference: plain 64-bit arithmetic on the w-bit interpretation of the operands
    function automatic logic [31:0] ref_alu(input int w, input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
        longint unsigned m, ua, ub, r;
        longint          sa, sb, half;
        int              sh;
        m    = (64'd1 << w) - 64'd1;
        ua   = 64'(a) & m;
        ub   = 64'(b) & m;
        half = longint'(64'd1 << (w - 1));
        sa   = (longint'(ua) >= half) ? longint'(ua) - 2 * half : longint'(ua);
        sb   = (longint'(ub) >= half) ? longint'(ub) - 2 * half : longint'(ub);
        sh   = int'(ub % 64'(w));
        r    = 0;
        case (c)
            6'h00, 6'h01: r = ua + ub;
            6'h02: r = (sa < sb) ? 1 : 0;
            6'h03: r = (ua < ub) ? 1 : 0;
            6'h04: r = ua << sh;
            6'h05: r = ua >> sh;
            6'h06: r = sa >>> sh;
            6'h07: r = ua ^ ub;
            6'h08: r = ua | ub;
            6'h09: r = ua & ub;
            6'h0A: r = ua - ub;
            6'h0B: r = sa * sb;
            6'h0C: r = (sa * sb) >>> w;
            6'h0D: r = (sa * longint'(ub)) >>> w;
            6'h0E: r = (ua * ub) >> w;
            6'h0F: if (ub == 0) r = m; else r = sa / sb;
            6'h10: if (ub == 0) r = m; else r = ua / ub;
            6'h11: if (ub == 0) r = ua; else r = sa % sb;
            6'h12: if (ub == 0) r = ua; else r = ua % ub;
            default: r = 0;
        endcase
        return 32'(r & m);
    endfunction

    // Clock edges between the accept edge and the first cycle showing out_valid
    function automatic int ref_lat(input int w, input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
        longint unsigned m, ua, ub;
        m  = (64'd1 << w) - 64'd1;
        ua = 64'(a) & m;
        ub = 64'(b) & m;
        if (c < 6'h0B || c > 6'h12) return 0;
        if (c >= 6'h0F && ub == 0) return 0;
        if ((c == 6'h0F || c == 6'h11) && ua == (64'd1 << (w - 1)) && ub == m) return 0;
        return w;
    endfunction

    task automatic do_op(input int w, input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int stall, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        check({tag, " in_ready"}, {31'b0, get_ir(w)}, 32'd1);
        drive(w, 1'b1, c, a, b);
        @(posedge clk);
        #1;
        drive(w, 1'b0, c, a, b);
        @(negedge clk);
        while (!get_ov(w) && n < 200) begin
            drive(w, 1'($urandom_range(0, 1)), 6'($urandom), $urandom, $urandom);
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        drive(w, 1'b0, 6'h0, 32'h0, 32'h0);
        check({tag, " latency"}, 32'(n), 32'(ref_lat(w, c, a, b)));
        check({tag, " result"}, get_res(w), exp);
        for (int i = 0; i < stall; i++) begin
            drive(w, 1'($urandom_range(0, 1)), 6'($urandom), $urandom, $urandom);
            @(posedge clk);
            @(negedge clk);
            check({tag, " stall result"}, get_res(w), exp);
            check({tag, " stall in_ready"}, {31'b0, get_ir(w)}, 32'd0);
            check({tag, " stall out_valid"}, {31'b0, get_ov(w)}, 32'd1);
        end
        drive(w, 1'b0, 6'h0, 32'h0, 32'h0);
        set_ready(w, 1'b1);
        @(posedge clk);
        #1;
        set_ready(w, 1'b0);
        @(negedge clk);
        check({tag, " idle in_ready"}, {31'b0, get_ir(w)}, 32'd1);
        check({tag, " idle out_valid"}, {31'b0, get_ov(w)}, 32'd0);
    endtask

    function automatic logic [31:0] rnd_opnd(input int w);
        logic [31:0] v, mask;
        mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        case ($urandom_range(0, 7))
            0: v = 32'h0;
            1: v = 32'h1;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'h1 << (w - 1);
            4: v = 32'($urandom_range(0, 20));
            default: v = $urandom;
        endcase
        return v & mask;
    endfunction

    int          w;
    logic [5:0]  c;
    logic [31:0] a, b;
    int          k;

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        drive(32, 1'b0, 6'h0, 32'h0, 32'h0);
        drive(16, 1'b0, 6'h0, 32'h0, 32'h0);
        out_ready32 = 1'b0;
        out_ready16 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset in_ready32", {31'b0, in_ready32}, 32'd1);
        check("reset out_valid32", {31'b0, out_valid32}, 32'd0);
        check("reset busy32", {31'b0, busy32}, 32'd0);
        check("reset result32", result32, 32'h0);
        check("reset in_ready16", {31'b0, in_ready16}, 32'd1);
        check("reset result16", {16'h0, result16}, 32'h0);
        rst_n = 1'b1;

        // Abort a divide after 5 busy cycles
        @(negedge clk);
        drive(32, 1'b1, 6'h0F, 32'd1000, 32'd3);
        @(posedge clk);
        #1;
        drive(32, 1'b0, 6'h0, 32'h0, 32'h0);
        repeat (5) @(posedge clk);
        #2;
        check("mid-div busy", {31'b0, busy32}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort out_valid", {31'b0, out_valid32}, 32'd0);
        check("abort busy", {31'b0, busy32}, 32'd0);
        check("abort in_ready", {31'b0, in_ready32}, 32'd1);
        check("abort result", result32, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(32, 6'h10, 32'd100, 32'd7, 32'd14, 0, "divu after reset");

        // Base ops
        do_op(32, 6'h01, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, "add wrap");
        do_op(32, 6'h0A, 32'h0, 32'h1, 32'hFFFF_FFFF, 0, "sub 0-1");
        do_op(32, 6'h06, 32'h8000_0000, 32'd4, 32'hF800_0000, 0, "sra");
        do_op(32, 6'h03, 32'h1, 32'hFFFF_FFFF, 32'h1, 0, "sltu");
        do_op(32, 6'h15, 32'h1234, 32'h5678, 32'h0, 0, "unknown code");
        do_op(32, 6'h3F, 32'h1234, 32'h5678, 32'h0, 0, "nop");

        // Multiply
        do_op(32, 6'h0B, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 0, "mul -1*-1");
        do_op(32, 6'h0C, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 0, "mulh -1*-1");
        do_op(32, 6'h0E, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, "mulhu");
        do_op(32, 6'h0D, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 0, "mulhsu -1,2");

        // Divide
        do_op(32, 6'h0F, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 0, "div -7/2");
        do_op(32, 6'h11, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 0, "rem -7%2");
        do_op(32, 6'h0F, 32'h0000_ABCD, 32'h0, 32'hFFFF_FFFF, 0, "div by zero");
        do_op(32, 6'h11, 32'h0000_ABCD, 32'h0, 32'h0000_ABCD, 0, "rem by zero");
        do_op(32, 6'h0F, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, "div overflow");
        do_op(32, 6'h11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0, "rem overflow");

        // Backpressure
        do_op(32, 6'h0B, 32'd1234, 32'd5678, 32'd7006652, 10, "mul backpressure");

        // Randomized ops against the reference model
        for (int i = 0; i < 160; i++) begin
            w = (i < 100) ? 32 : 16;
            k = $urandom_range(0, 20);
            c = (k <= 18) ? 6'(k) : ((k == 19) ? 6'h3F : 6'h15);
            a = rnd_opnd(w);
            b = rnd_opnd(w);
            do_op(w, c, a, b, ref_alu(w, c, a, b), $urandom_range(0, 3),
                  $sformatf("rand w%0d op%02h", w, c));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
